// File: rtl/wbs_mem_bridge.sv
// Wishbone slave that maps host bus cycles onto the ANN core's load and
// readback ports: node/leaf memory writes, query FIFO pushes, best-index
// memory reads and a small control/status register bank.
module wbs_mem_bridge #(
   parameter int DATA_WIDTH = 11,
   parameter int NODE_AW    = 6,
   parameter int LEAF_AW    = 12,
   parameter int BEST_AW    = 10
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic                    node_wen,
   output logic [NODE_AW-1:0]      node_waddr,
   output logic [2*DATA_WIDTH-1:0] node_wdata,
   output logic                    leaf_wen,
   output logic [LEAF_AW-1:0]      leaf_waddr,
   output logic [DATA_WIDTH-1:0]   leaf_wdata,
   output logic                    query_wenq,
   output logic [DATA_WIDTH-1:0]   query_wdata,
   input  logic                    query_wfull_n,
   output logic                    best_ren,
   output logic [BEST_AW-1:0]      best_raddr,
   input  logic [DATA_WIDTH-1:0]   best_rdata,
   output logic                    fsm_start,
   input  logic                    fsm_done,
   input  logic                    fsm_busy,
   output logic                    mode,
   output logic                    debug
);

   typedef enum logic [1:0] {
      IDLE,
      WSTALL,
      RWAIT,
      ACK
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] datOut_q, datOut_d;
   logic        mode_q, mode_d;
   logic        debug_q, debug_d;

   logic        request;
   logic        hit;
   logic [3:0]  region;
   logic [15:0] offset;
   logic        selRegs, selQuery, selLeaf, selBest, selNode;
   logic        nodeInRange, leafInRange, bestInRange;
   logic [31:0] regRdata;
   logic        unusedBits;

   // Address decode: the 0x300x_xxxx window, one 64K region per target.
   assign request  = wbs_cyc_i & wbs_stb_i;
   assign hit      = ((wbs_adr_i[31:16] & 16'hFFF0) == 16'h3000);
   assign region   = wbs_adr_i[19:16];
   assign offset   = wbs_adr_i[15:0];
   assign selRegs  = hit && (region == 4'd0);
   assign selQuery = hit && (region == 4'd1);
   assign selLeaf  = hit && (region == 4'd2);
   assign selBest  = hit && (region == 4'd3);
   assign selNode  = hit && (region == 4'd4);

   // Heap index 0 is not a real node, so it is excluded from the node range.
   assign nodeInRange = (offset[15:NODE_AW] == '0) && (offset != 16'd0);
   assign leafInRange = (offset[15:LEAF_AW] == '0);
   assign bestInRange = (offset[15:BEST_AW] == '0);

   assign node_waddr  = wbs_adr_i[NODE_AW-1:0];
   assign node_wdata  = wbs_dat_i[2*DATA_WIDTH-1:0];
   assign leaf_waddr  = wbs_adr_i[LEAF_AW-1:0];
   assign leaf_wdata  = wbs_dat_i[DATA_WIDTH-1:0];
   assign query_wdata = wbs_dat_i[DATA_WIDTH-1:0];
   assign best_raddr  = wbs_adr_i[BEST_AW-1:0];

   assign wbs_dat_o = datOut_q;
   assign mode      = mode_q;
   assign debug     = debug_q;

   // Byte selects and upper data bits carry no meaning for this bridge.
   assign unusedBits = ^{wbs_sel_i, wbs_dat_i[31:2*DATA_WIDTH]};

   // Control/status register readback, selected by byte offset.
   always_comb begin
      regRdata = 32'h0;
      case (offset)
         16'h0000: regRdata = {31'b0, mode_q};
         16'h0004: regRdata = {31'b0, debug_q};
         16'h0008: regRdata = {31'b0, fsm_done};
         16'h0010: regRdata = {31'b0, fsm_busy};
         default:  regRdata = 32'h0;
      endcase
   end

   // State, read-data and control registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         datOut_q <= 32'h0;
         mode_q   <= 1'b0;
         debug_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         datOut_q <= datOut_d;
         mode_q   <= mode_d;
         debug_q  <= debug_d;
      end
   end

   // Transaction sequencing: side effects fire in the cycle a request is
   // accepted, then a single ACK cycle in which no new request is taken.
   // Strobes are held low while reset is asserted so a cancelled stall
   // cannot leak a push.
   always_comb begin
      state_d    = state_q;
      datOut_d   = datOut_q;
      mode_d     = mode_q;
      debug_d    = debug_q;
      node_wen   = 1'b0;
      leaf_wen   = 1'b0;
      query_wenq = 1'b0;
      best_ren   = 1'b0;
      fsm_start  = 1'b0;
      wbs_ack_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (request) begin
               if (selBest && !wbs_we_i && bestInRange) begin
                  best_ren = 1'b1;
                  state_d  = RWAIT;
               end else if (selQuery && wbs_we_i && !query_wfull_n) begin
                  state_d = WSTALL;
               end else begin
                  state_d = ACK;
                  if (wbs_we_i) begin
                     node_wen   = selNode && nodeInRange;
                     leaf_wen   = selLeaf && leafInRange;
                     query_wenq = selQuery;
                     if (selRegs) begin
                        case (offset)
                           16'h0000: mode_d    = wbs_dat_i[0];
                           16'h0004: debug_d   = wbs_dat_i[0];
                           16'h000C: fsm_start = wbs_dat_i[0];
                           default:  ;
                        endcase
                     end
                  end else begin
                     datOut_d = selRegs ? regRdata : 32'h0;
                  end
               end
            end
         end
         WSTALL: begin
            if (!wbs_cyc_i) begin
               state_d = IDLE;
            end else if (query_wfull_n) begin
               query_wenq = 1'b1;
               state_d    = ACK;
            end
         end
         RWAIT: begin
            if (!wbs_cyc_i) begin
               state_d = IDLE;
            end else begin
               datOut_d = 32'(best_rdata);
               state_d  = ACK;
            end
         end
         ACK: begin
            wbs_ack_o = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (wb_rst_i) begin
         node_wen   = 1'b0;
         leaf_wen   = 1'b0;
         query_wenq = 1'b0;
         best_ren   = 1'b0;
         fsm_start  = 1'b0;
         wbs_ack_o  = 1'b0;
      end
   end

endmodule
